// File: rtl/lvds_check_sequencer.sv
// rtl/lvds_check_sequencer.sv - steps the shared LVDS status checker through enabled channels
// Optional build macro: LVDS_SEQ_CONTINUOUS_EN (adds run_cont for back-to-back scans).
module lvds_check_sequencer #(
  parameter int N_CH         = 8,
  parameter int TICK_DIV     = 100,
  parameter int SETTLE_TICKS = 2,
  parameter int WINDOWS      = 8
) (
  input  logic            clk_100Mz,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            ready_in,
`ifdef LVDS_SEQ_CONTINUOUS_EN
  input  logic            run_cont,
`endif
  output logic [2:0]      ch_sel,
  output logic [2:0]      win_cnt,
  output logic            tick_1us,
  output logic            clr_meas,
  output logic            busy,
  output logic            done,
  output logic [N_CH-1:0] result
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_TICKS - 1);
  localparam logic [2:0]       WIN_LAST    = 3'(WINDOWS - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, SAMPLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [3:0]       settle_q, settle_nxt;
  logic [N_CH-1:0]  mask_q, mask_nxt, result_nxt;
  logic [2:0]       ch_sel_nxt, win_nxt;
  logic             clr_nxt, launch, running;
  logic [3:0]       first_hit, next_hit;

  // Returns {found, index} of the lowest set bit of m at or above lo.
  function automatic logic [3:0] lowest_from(input logic [N_CH-1:0] m, input int lo);
    lowest_from = 4'b0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i] && i >= lo) lowest_from = {1'b1, 3'(i)};
  endfunction

  assign first_hit = lowest_from(ch_mask, 0);
  assign next_hit  = lowest_from(mask_q, int'(ch_sel) + 1);

  always_comb begin
    state_nxt  = state;
    ch_sel_nxt = ch_sel;
    win_nxt    = win_cnt;
    settle_nxt = settle_q;
    div_nxt    = div_q;
    result_nxt = result;
    mask_nxt   = mask_q;
    clr_nxt    = 1'b0;
    launch     = 1'b0;
    running    = (state == SETTLE) || (state == MEASURE);
    tick_1us   = running && (div_q == DIV_LAST);
    busy       = running || (state == SAMPLE);
    done       = (state == DONE);

    if (running) div_nxt = tick_1us ? '0 : div_q + DIV_W'(1);

    case (state)
      IDLE: if (start) launch = 1'b1;
      SETTLE: begin
        if (tick_1us) begin
          if (settle_q == SETTLE_LAST) begin
            state_nxt = MEASURE;
            win_nxt   = 3'd0;
          end else begin
            settle_nxt = settle_q + 4'd1;
          end
        end
      end
      MEASURE: begin
        if (tick_1us) begin
          if (win_cnt == WIN_LAST) state_nxt = SAMPLE;
          else                     win_nxt   = win_cnt + 3'd1;
        end
      end
      SAMPLE: begin
        result_nxt[ch_sel[IDX_W-1:0]] = ready_in;
        if (next_hit[3]) begin
          ch_sel_nxt = next_hit[2:0];
          clr_nxt    = 1'b1;
          div_nxt    = '0;
          settle_nxt = 4'd0;
          state_nxt  = SETTLE;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
`ifdef LVDS_SEQ_CONTINUOUS_EN
        if (run_cont) launch = 1'b1;
`endif
      end
      default: state_nxt = IDLE;
    endcase

    // A restart from DONE keeps the previous result; only a host start clears it.
    if (launch) begin
      mask_nxt   = ch_mask;
      div_nxt    = '0;
      settle_nxt = 4'd0;
      if (state == IDLE) result_nxt = '0;
      if (first_hit[3]) begin
        ch_sel_nxt = first_hit[2:0];
        clr_nxt    = 1'b1;
        state_nxt  = SETTLE;
      end else begin
        state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk_100Mz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch_sel   <= 3'd0;
      win_cnt  <= 3'd0;
      settle_q <= 4'd0;
      div_q    <= '0;
      mask_q   <= '0;
      result   <= '0;
      clr_meas <= 1'b0;
    end else begin
      state    <= state_nxt;
      ch_sel   <= ch_sel_nxt;
      win_cnt  <= win_nxt;
      settle_q <= settle_nxt;
      div_q    <= div_nxt;
      mask_q   <= mask_nxt;
      result   <= result_nxt;
      clr_meas <= clr_nxt;
    end
  end

endmodule
